// File: rtl/dmem_access_sequencer_if.sv
// Data-memory bus between the access sequencer and a
// single-port, variable-latency memory.
interface dmem_access_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/dmem_access_sequencer.sv
// Sequences MemRead/MemWrite onto a single-port data memory;
// read+write becomes an atomic read-then-write pair.
module dmem_access_sequencer #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] link_data,
   output logic              stall,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              bus_err,
   dmem_access_sequencer_if.master mem
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      RMW_RD,
      RMW_WR,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             ack;
   logic             tmo;
   logic             busy;

   // Acks only count while a request is actually on the bus.
   assign ack  = mem.mem_req & mem.mem_ack;
   assign tmo  = mem.mem_req & ~mem.mem_ack &
                 (wait_cnt == CNT_W'(MAX_WAIT - 1));
   assign busy = (state == RD) | (state == WR) |
                 (state == RMW_RD) | (state == RMW_WR);
   assign stall = ((state == IDLE) & (mem_read | mem_write))
                  | busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         rdata         <= '0;
         rdata_valid   <= 1'b0;
         bus_err       <= 1'b0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
      end else begin
         rdata_valid <= 1'b0;
         bus_err     <= 1'b0;
         unique case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (mem_read | mem_write) begin
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= mem_write & ~mem_read;
                  mem.mem_addr  <= addr;
                  mem.mem_wdata <= wdata;
                  if (mem_read & mem_write)
                     state <= RMW_RD;
                  else if (mem_read)
                     state <= RD;
                  else
                     state <= WR;
               end
            end
            RD, WR, RMW_RD, RMW_WR: begin
               if (ack) begin
                  mem.mem_req <= 1'b0;
                  wait_cnt    <= '0;
                  if ((state == RD) || (state == RMW_RD))
                     rdata <= mem.mem_rdata;
                  if (state == RMW_RD) begin
                     mem.mem_we    <= 1'b1;
                     mem.mem_wdata <= link_data;
                     state         <= RMW_WR;
                  end else begin
                     rdata_valid <= (state == RD) |
                                    (state == RMW_WR);
                     state       <= DONE;
                  end
               end else if (tmo) begin
                  mem.mem_req <= 1'b0;
                  rdata       <= '0;
                  bus_err     <= 1'b1;
                  state       <= DONE;
               end else if (mem.mem_req) begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end else begin
                  // Write half of a pair issues after one idle bus cycle.
                  mem.mem_req <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
